// File: rtl/bsearch_engine_if.sv
// Request/result and RAM-read signals of the binary-search engine, bundled
// so the engine, the table RAM and the control logic share one connection.
interface bsearch_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  // Handshake: start is sampled only while the engine is idle; the accepting
  // edge latches key/mode/count, busy rises the next cycle, and done pulses for
  // exactly one cycle with found/eq/result_addr/probes valid (they then hold
  // until the next search completes). start, key, mode and count are ignored
  // while busy. RAM reads: rd_en is a one-cycle strobe with rd_addr, and
  // rd_data must be valid RD_LAT cycles later.
  logic              start;
  logic [DATA_W-1:0] key;
  logic              mode;
  logic [ADDR_W:0]   count;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic              busy;
  logic              done;
  logic              found;
  logic              eq;
  logic [ADDR_W-1:0] result_addr;
  logic [ADDR_W:0]   probes;

  modport master (
    output start, key, mode, count, rd_data,
    input  rd_en, rd_addr, busy, done, found, eq, result_addr, probes
  );

  modport slave (
    input  start, key, mode, count, rd_data,
    output rd_en, rd_addr, busy, done, found, eq, result_addr, probes
  );
endinterface

// File: rtl/bsearch_engine.sv
// Binary search over an external sorted synchronous RAM, exact-match or
// lower-bound mode, tolerating a fixed RAM read latency.
module bsearch_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  bsearch_engine_if.slave     bus,
  output logic [2:0]          dbg_state
);

  localparam int IDX_W  = ADDR_W + 1;
  localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [IDX_W-1:0] DEPTH = IDX_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  lo;
  logic [IDX_W-1:0]  hi;
  logic [IDX_W-1:0]  mid;
  logic [DATA_W-1:0] key_r;
  logic              mode_r;
  logic [IDX_W-1:0]  cnt_r;
  logic              eq_r;
  logic [IDX_W-1:0]  probe_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic [IDX_W-1:0]  count_clamped;
  logic [IDX_W-1:0]  lo_n;
  logic [IDX_W-1:0]  hi_n;
  logic [IDX_W-1:0]  mid_n;
  logic              eq_n;
  logic              hit;
  logic              lb_found;

  assign dbg_state = state;

  always_comb begin
    count_clamped = (bus.count > DEPTH) ? DEPTH : bus.count;
  end

  // Interval update for the probe whose data is on rd_data in COMPARE.
  // mid is always < hi, so mid+1 never exceeds DEPTH and fits IDX_W bits.
  always_comb begin
    lo_n = lo;
    hi_n = hi;
    eq_n = eq_r;
    hit  = 1'b0;
    if (mode_r) begin
      if (bus.rd_data >= key_r) begin
        hi_n = mid;
        eq_n = (bus.rd_data == key_r);
      end else begin
        lo_n = mid + IDX_W'(1);
      end
    end else begin
      if (bus.rd_data == key_r) begin
        hit = 1'b1;
      end else if (bus.rd_data < key_r) begin
        lo_n = mid + IDX_W'(1);
      end else begin
        hi_n = mid;
      end
    end
    mid_n    = lo_n + ((hi_n - lo_n) >> 1);
    lb_found = (lo_n < cnt_r);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      lo              <= '0;
      hi              <= '0;
      mid             <= '0;
      key_r           <= '0;
      mode_r          <= 1'b0;
      cnt_r           <= '0;
      eq_r            <= 1'b0;
      probe_cnt       <= '0;
      wait_cnt        <= '0;
      bus.rd_en       <= 1'b0;
      bus.rd_addr     <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.found       <= 1'b0;
      bus.eq          <= 1'b0;
      bus.result_addr <= '0;
      bus.probes      <= '0;
    end else begin
      bus.done  <= 1'b0;
      bus.rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            key_r     <= bus.key;
            mode_r    <= bus.mode;
            cnt_r     <= count_clamped;
            lo        <= '0;
            hi        <= count_clamped;
            eq_r      <= 1'b0;
            probe_cnt <= '0;
            bus.busy  <= 1'b1;
            if (count_clamped == '0) begin
              // Empty table: report not-found without touching the RAM.
              state           <= S_DONE;
              bus.done        <= 1'b1;
              bus.found       <= 1'b0;
              bus.eq          <= 1'b0;
              bus.result_addr <= '0;
              bus.probes      <= '0;
            end else begin
              state       <= S_ISSUE;
              mid         <= count_clamped >> 1;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= ADDR_W'(count_clamped >> 1);
            end
          end
        end

        S_ISSUE: begin
          probe_cnt <= probe_cnt + IDX_W'(1);
          wait_cnt  <= WAIT_W'(RD_LAT > 1 ? RD_LAT - 2 : 0);
          if (RD_LAT == 1) begin
            state <= S_COMPARE;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_COMPARE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end

        S_COMPARE: begin
          lo   <= lo_n;
          hi   <= hi_n;
          eq_r <= eq_n;
          mid  <= mid_n;
          if (!mode_r && hit) begin
            state           <= S_DONE;
            bus.done        <= 1'b1;
            bus.found       <= 1'b1;
            bus.eq          <= 1'b1;
            bus.result_addr <= ADDR_W'(mid);
            bus.probes      <= probe_cnt;
          end else if (!mode_r && (lo_n >= hi_n)) begin
            state           <= S_DONE;
            bus.done        <= 1'b1;
            bus.found       <= 1'b0;
            bus.eq          <= 1'b0;
            bus.result_addr <= '0;
            bus.probes      <= probe_cnt;
          end else if (mode_r && (lo_n == hi_n)) begin
            // Interval collapsed onto the first entry >= key (or onto count).
            state           <= S_DONE;
            bus.done        <= 1'b1;
            bus.found       <= lb_found;
            bus.eq          <= lb_found & eq_n;
            bus.result_addr <= lb_found ? ADDR_W'(lo_n) : '0;
            bus.probes      <= probe_cnt;
          end else begin
            state       <= S_ISSUE;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= ADDR_W'(mid_n);
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsearch_engine.sv
// Directed bench for bsearch_engine: RAM model with RD_LAT=2 and mem[i]=2i+1,
// hand-computed search results, probe sequences and done timing.
module tb_bsearch_engine;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int RD_LAT = 2;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  bsearch_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bsearch_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] pipe [RD_LAT];

  always @(posedge clk) begin
    if (bus.rd_en) pipe[0] <= mem[bus.rd_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rd_data = pipe[RD_LAT-1];

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = DATA_W'(2 * i + 1);
  endtask

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [12:0] exp_q[$];
  logic [4:0]  addr_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one search; optionally pulses a conflicting start while busy.
  task automatic run_search(input string tag, input logic [7:0] k, input logic m,
                            input logic [5:0] c, input logic e_found, input logic e_eq,
                            input logic [4:0] e_addr, input logic [5:0] e_probes,
                            input bit poke);
    int cyc;
    int reads;
    logic [12:0] exp;
    exp_q.push_back({e_found, e_eq, e_addr, e_probes});
    addr_log.delete();
    @(negedge clk);
    bus.key = k; bus.mode = m; bus.count = c; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    reads = 0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && cyc < 200) begin
      if (bus.rd_en) begin
        reads++;
        addr_log.push_back(bus.rd_addr);
      end
      if (poke && cyc == 4) begin
        bus.start = 1'b1; bus.key = 8'd63; bus.mode = ~m; bus.count = 6'd3;
      end else if (poke && cyc == 5) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    exp = exp_q.pop_front();
    if (!bus.done) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_result"}, 32'({bus.found, bus.eq, bus.result_addr, bus.probes}), 32'(exp));
      check({tag, "_done_cycle"}, 32'(cyc), 32'(e_probes) * 3 + 1);
      check({tag, "_reads"}, 32'(reads), 32'(e_probes));
    end
    @(negedge clk);
    check({tag, "_idle_after"}, 32'({bus.busy, bus.done}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    logic [4:0] exp_addrs [5];
    bus.start = 1'b0; bus.key = '0; bus.mode = 1'b0; bus.count = 6'd32;
    fill_mem();
    for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_outputs",
          32'({bus.busy, bus.done, bus.found, bus.eq, bus.rd_en, bus.result_addr, bus.rd_addr, bus.probes}),
          32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);

    // exact hit: probe sequence 16, 8, 12, 10, 9
    run_search("exact_19", 8'd19, 1'b0, 6'd32, 1'b1, 1'b1, 5'd9, 6'd5, 1'b0);
    exp_addrs = '{5'd16, 5'd8, 5'd12, 5'd10, 5'd9};
    check("exact_19_nprobe_addrs", 32'(addr_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++)
      check($sformatf("exact_19_addr%0d", i), 32'(addr_log[i]), 32'(exp_addrs[i]));

    run_search("exact_20", 8'd20, 1'b0, 6'd32, 1'b0, 1'b0, 5'd0, 6'd5, 1'b0);
    run_search("lb_20",    8'd20, 1'b1, 6'd32, 1'b1, 1'b0, 5'd10, 6'd5, 1'b0);
    run_search("lb_0",     8'd0,  1'b1, 6'd32, 1'b1, 1'b0, 5'd0, 6'd6, 1'b0);
    // all entries below key: interval walks right, 16,24,28,30,31
    run_search("lb_64",    8'd64, 1'b1, 6'd32, 1'b0, 1'b0, 5'd0, 6'd5, 1'b0);
    run_search("lb_8_c10", 8'd8,  1'b1, 6'd10, 1'b1, 1'b0, 5'd4, 6'd4, 1'b0);
    run_search("count0",   8'd5,  1'b0, 6'd0,  1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
    // count clamps to 32: probes 16,24,28,30,31
    run_search("clamp40",  8'd63, 1'b0, 6'd40, 1'b1, 1'b1, 5'd31, 6'd5, 1'b0);

    for (int i = 7; i <= 11; i++) mem[i] = 8'd15;
    run_search("lb_dup15", 8'd15, 1'b1, 6'd32, 1'b1, 1'b1, 5'd7, 6'd5, 1'b0);
    fill_mem();

    run_search("poke_busy", 8'd19, 1'b0, 6'd32, 1'b1, 1'b1, 5'd9, 6'd5, 1'b1);
    run_search("after_poke", 8'd20, 1'b1, 6'd32, 1'b1, 1'b0, 5'd10, 6'd5, 1'b0);

    // reset during WAIT of the third probe (cycle 8 after the accept edge)
    @(negedge clk);
    bus.key = 8'd19; bus.mode = 1'b0; bus.count = 6'd32; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_state_wait", 32'(dbg_state), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_outputs",
          32'({bus.busy, bus.done, bus.found, bus.eq, bus.rd_en, bus.result_addr, bus.rd_addr, bus.probes}),
          32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rst_no_done%0d", i), 32'({bus.done, bus.busy}), 32'd0);
    end
    run_search("after_reset", 8'd19, 1'b0, 6'd32, 1'b1, 1'b1, 5'd9, 6'd5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
